// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router: stores {hdr_flag, byte} words and tracks the
// remaining length of the packet being read so data_out idles at zero between packets.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int CW = WIDTH - 2;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH:0]   mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [CW-1:0]    pkt_cnt_r;
  logic [WIDTH-1:0] data_out_r;

  logic             full_s;
  logic             empty_s;
  logic             flush_s;
  logic             wr_accept_s;
  logic             rd_accept_s;
  logic [WIDTH:0]   rd_word_s;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign flush_s     = reset | soft_reset;
  assign wr_accept_s = write_enb & ~full_s;
  assign rd_accept_s = read_enb & ~empty_s;
  assign rd_word_s   = mem_r[rd_ptr_r[AW-1:0]];

  assign full     = full_s;
  assign empty    = empty_s;
  assign data_out = data_out_r;

  // storage array; a flush only moves the pointers, so contents are left as they are
  always_ff @(posedge clk) begin
    if (!flush_s && wr_accept_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // pointers, packet length tracking and registered read data
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      pkt_cnt_r  <= {CW{1'b0}};
      data_out_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        data_out_r <= rd_word_s[WIDTH-1:0];
        // header byte is {len, addr}; remaining words are payload plus parity
        if (rd_word_s[WIDTH]) begin
          pkt_cnt_r <= rd_word_s[WIDTH-1:2] + CNT_ONE;
        end else if (pkt_cnt_r != {CW{1'b0}}) begin
          pkt_cnt_r <= pkt_cnt_r - CNT_ONE;
        end
      end else if (pkt_cnt_r == {CW{1'b0}}) begin
        data_out_r <= {WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed and randomized bench for router_fifo, checked cycle by cycle against a
// queue-based model of the FIFO and its packet-length rules.
module tb_router_fifo;

  logic       clk;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_checks;
  int n_fail;

  logic [8:0] m_q[$];
  int         m_cnt;
  logic [7:0] m_dout;

  router_fifo #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, compare just after it
  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic rs, input logic srs);
    logic [8:0] w;
    bit         acc_w;
    bit         acc_r;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    reset      = rs;
    soft_reset = srs;
    @(posedge clk);
    if (rs || srs) begin
      m_q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
    end else begin
      acc_w = we && (m_q.size() < 16);
      acc_r = re && (m_q.size() > 0);
      if (acc_r) begin
        w      = m_q.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = ((int'(w[7:0]) / 4) + 1) % 64;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (acc_w) m_q.push_back({lfd, din});
    end
    #1;
    check_eq("data_out", 32'(data_out), 32'(m_dout));
    check_eq("full", 32'(full), 32'(m_q.size() == 16));
    check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    step(1'b1, 1'b0, lfd, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt [5];
    logic [7:0] held;
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_dout   = 8'h00;
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;

    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("reset_empty", 32'(empty), 32'd1);
    check_eq("reset_dout", 32'(data_out), 32'h0);

    // T1: reset in the middle of traffic
    wr(1'b1, 8'h15); wr(1'b0, 8'hA1); rd(); wr(1'b0, 8'hA2);
    step(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h5B, 1'b1, 1'b0);
    check_eq("t1_empty", 32'(empty), 32'd1);
    check_eq("t1_full", 32'(full), 32'd0);
    check_eq("t1_dout", 32'(data_out), 32'h0);

    // T2: one packet, header len=3
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      check_eq("t2_byte", 32'(data_out), 32'(pkt[i]));
    end
    idle();
    check_eq("t2_idle_zero", 32'(data_out), 32'h0);

    // T3: fill, overflow write, drain
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'h80 + i));
    check_eq("t3_full", 32'(full), 32'd1);
    wr(1'b0, 8'hEE);
    for (int i = 0; i < 16; i++) begin
      rd();
      check_eq("t3_order", 32'(data_out), 32'(8'h80 + i));
    end
    check_eq("t3_empty", 32'(empty), 32'd1);

    // T4: steady occupancy 3 across a pointer wrap
    for (int i = 0; i < 3; i++) wr(1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h33 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd();
    check_eq("t4_last", 32'(data_out), 32'(8'h33 + 39));

    // T5: simultaneous read+write at full and at empty
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    check_eq("t5_full_rd", 32'(data_out), 32'hC0);
    check_eq("t5_not_full", 32'(full), 32'd0);
    for (int i = 0; i < 15; i++) rd();
    check_eq("t5_no_extra", 32'(empty), 32'd1);
    wr(1'b1, 8'h1D); wr(1'b0, 8'h77);
    rd(); rd();
    held = data_out;
    step(1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    check_eq("t5_empty_hold", 32'(data_out), 32'(held));
    check_eq("t5_wr_taken", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // T6: soft_reset mid-packet, then a fresh packet
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    rd(); rd();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_eq("t6_dout", 32'(data_out), 32'h0);
    wr(1'b1, 8'h09); wr(1'b0, 8'h5A); wr(1'b0, 8'h6B); wr(1'b0, 8'h7C);
    for (int i = 0; i < 4; i++) rd();
    check_eq("t6_parity", 32'(data_out), 32'h7C);
    idle();
    check_eq("t6_idle", 32'(data_out), 32'h0);

    // randomized traffic with occasional flushes
    for (int i = 0; i < 4000; i++) begin
      logic we;
      logic re;
      logic lfd;
      logic rs;
      logic srs;
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 5) == 0);
      rs  = ($urandom_range(0, 499) == 0);
      srs = ($urandom_range(0, 299) == 0);
      step(we, re, lfd, 8'($urandom), rs, srs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
